spi_mem_responder: RTL and testbench

SPI_MEM_RESPONDER -- requirements
Module: spi_mem_responder

---
 rtl/spi_mem_pkg.sv | 26 ++
 rtl/spi_mem_array.sv | 37 +++
 rtl/spi_mem_responder.sv | 206 ++++++++++++++++++++
 tb/tb_spi_mem_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// Shared constants for the SPI memory responder family: opcodes, widths and
// the responder state encoding.
package spi_mem_pkg;

   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned ADDR_BYTES = 3;

   // Opcodes already used by other responders on this bus
   localparam logic [7:0] OP_WREN = 8'h06;
   localparam logic [7:0] OP_RDSR = 8'h05;
   localparam logic [7:0] OP_RDID = 8'h9F;

   // Default read/write opcodes for spi_mem_responder
   localparam logic [7:0] CMD_READ_DEF  = 8'h03;
   localparam logic [7:0] CMD_WRITE_DEF = 8'h02;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CMD     = 3'd1,
      ST_ADDR    = 3'd2,
      ST_RD_DATA = 3'd3,
      ST_WR_DATA = 3'd4,
      ST_IGNORE  = 3'd5
   } state_t;

endpackage

// File: rtl/spi_mem_array.sv
// Byte memory behind the SPI responder.
// Ports: rd_addr/rd_data_c  asynchronous read port
//        load_*             backdoor write (has priority)
//        spi_we/addr/data   write from the SPI side
// Contents are not reset.
module spi_mem_array
   import spi_mem_pkg::*;
#(
   parameter int unsigned DEPTH_BITS = 8
) (
   input  logic                  clk,
   input  logic [DEPTH_BITS-1:0] rd_addr,
   output logic [BYTE_W-1:0]     rd_data_c,
   input  logic                  load_en,
   input  logic [DEPTH_BITS-1:0] load_addr,
   input  logic [BYTE_W-1:0]     load_data,
   input  logic                  spi_we,
   input  logic [DEPTH_BITS-1:0] spi_addr,
   input  logic [BYTE_W-1:0]     spi_data
);

   localparam int unsigned MEM_BYTES = 1 << DEPTH_BITS;

   logic [BYTE_W-1:0] mem [MEM_BYTES];

   assign rd_data_c = mem[rd_addr];

   // Single write port: a backdoor load in the same cycle drops the SPI byte
   always_ff @(posedge clk) begin
      if (load_en) begin
         mem[load_addr] <= load_data;
      end else if (spi_we) begin
         mem[spi_addr] <= spi_data;
      end
   end

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 memory responder (command, 24-bit address, streaming data).
// Ports: clk/rst          system clock, synchronous active-high reset
//        sclk/mosi/cs_n   SPI inputs, asynchronous to clk
//        miso/miso_oe     serial data out and its enable
//        load_*           backdoor byte write into the memory
//        busy             frame in progress
//        cmd_err          sticky unrecognised-command flag
module spi_mem_responder
   import spi_mem_pkg::*;
#(
   parameter int unsigned DEPTH_BITS = 8,
   parameter logic [7:0]  CMD_READ   = CMD_READ_DEF,
   parameter logic [7:0]  CMD_WRITE  = CMD_WRITE_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sclk,
   input  logic                  mosi,
   input  logic                  cs_n,
   output logic                  miso,
   output logic                  miso_oe,
   input  logic                  load_en,
   input  logic [DEPTH_BITS-1:0] load_addr,
   input  logic [7:0]            load_data,
   output logic                  busy,
   output logic                  cmd_err
);

   state_t state, state_nxt;

   logic sclk_meta, sclk_sync, sclk_prev;
   logic mosi_meta, mosi_sync;
   logic cs_meta, cs_sync, cs_prev;

   logic [2:0]            bit_cnt;
   logic [1:0]            byte_cnt;
   logic [BYTE_W-1:0]     rx_sh;
   logic [BYTE_W-1:0]     tx_sh;
   logic [DEPTH_BITS-1:0] addr_sh;
   logic [DEPTH_BITS-1:0] ptr;
   logic                  is_read;
   logic                  reload;

   logic                  sclk_rise_c, sclk_fall_c, cs_fall_c;
   logic [BYTE_W-1:0]     rx_byte_c;
   logic [DEPTH_BITS-1:0] addr_c;
   logic [BYTE_W-1:0]     rd_data_c;
   logic                  start_c, rx_en_c, cmd_bad_c, ptr_load_c, spi_we_c, tx_en_c;

   assign sclk_rise_c = sclk_sync & ~sclk_prev;
   assign sclk_fall_c = ~sclk_sync & sclk_prev;
   assign cs_fall_c   = ~cs_sync & cs_prev;
   assign rx_byte_c   = {rx_sh[BYTE_W-2:0], mosi_sync};
   // Only the low DEPTH_BITS of the 24-bit address are kept
   assign addr_c      = {addr_sh[DEPTH_BITS-2:0], mosi_sync};

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; deselect always returns to IDLE
   always_comb begin
      state_nxt = state;
      if (cs_sync) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (cs_fall_c) state_nxt = ST_CMD;
            ST_CMD: begin
               if (sclk_rise_c && bit_cnt == 3'd7) begin
                  if (rx_byte_c == CMD_READ || rx_byte_c == CMD_WRITE) state_nxt = ST_ADDR;
                  else                                                  state_nxt = ST_IGNORE;
               end
            end
            ST_ADDR: begin
               if (sclk_rise_c && bit_cnt == 3'd7 && byte_cnt == 2'(ADDR_BYTES - 1))
                  state_nxt = is_read ? ST_RD_DATA : ST_WR_DATA;
            end
            default: state_nxt = state;
         endcase
      end
   end

   // Datapath strobes decoded from state and synchronised SPI events
   always_comb begin
      start_c    = 1'b0;
      rx_en_c    = 1'b0;
      cmd_bad_c  = 1'b0;
      ptr_load_c = 1'b0;
      spi_we_c   = 1'b0;
      tx_en_c    = 1'b0;
      if (!cs_sync) begin
         case (state)
            ST_IDLE: start_c = cs_fall_c;
            ST_CMD: begin
               rx_en_c   = sclk_rise_c;
               cmd_bad_c = (state_nxt == ST_IGNORE);
            end
            ST_ADDR: begin
               rx_en_c    = sclk_rise_c;
               ptr_load_c = (state_nxt != ST_ADDR);
            end
            ST_WR_DATA: begin
               rx_en_c  = sclk_rise_c;
               spi_we_c = sclk_rise_c && (bit_cnt == 3'd7);
            end
            ST_RD_DATA: tx_en_c = sclk_fall_c;
            default: ;
         endcase
      end
   end

   // Synchronisers, counters, shift registers and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_meta <= 1'b0;
         sclk_sync <= 1'b0;
         sclk_prev <= 1'b0;
         mosi_meta <= 1'b0;
         mosi_sync <= 1'b0;
         cs_meta   <= 1'b1;
         cs_sync   <= 1'b1;
         cs_prev   <= 1'b1;
         bit_cnt   <= '0;
         byte_cnt  <= '0;
         rx_sh     <= '0;
         tx_sh     <= '0;
         addr_sh   <= '0;
         ptr       <= '0;
         is_read   <= 1'b0;
         reload    <= 1'b0;
         miso      <= 1'b0;
         miso_oe   <= 1'b0;
         busy      <= 1'b0;
         cmd_err   <= 1'b0;
      end else begin
         sclk_meta <= sclk;
         sclk_sync <= sclk_meta;
         sclk_prev <= sclk_sync;
         mosi_meta <= mosi;
         mosi_sync <= mosi_meta;
         cs_meta   <= cs_n;
         cs_sync   <= cs_meta;
         cs_prev   <= cs_sync;
         // Loaded from the same flop as cs_sync, so it tracks ~cs_sync exactly
         miso_oe   <= ~cs_meta;
         busy      <= (state_nxt != ST_IDLE);
         reload    <= 1'b0;

         if (cmd_bad_c) cmd_err <= 1'b1;

         if (start_c) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
         end

         if (rx_en_c) begin
            bit_cnt <= bit_cnt + 3'd1;
            rx_sh   <= rx_byte_c;
            if (state == ST_CMD && bit_cnt == 3'd7) is_read <= (rx_byte_c == CMD_READ);
            if (state == ST_ADDR) begin
               addr_sh <= addr_c;
               if (bit_cnt == 3'd7) byte_cnt <= byte_cnt + 2'd1;
            end
         end

         // Pointer moves first; the byte it selects is captured one cycle later
         if (ptr_load_c) begin
            ptr    <= addr_c;
            reload <= 1'b1;
         end
         if (spi_we_c) ptr <= ptr + DEPTH_BITS'(1);
         if (reload)   tx_sh <= rd_data_c;

         if (tx_en_c) begin
            miso    <= tx_sh[BYTE_W-1];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               ptr    <= ptr + DEPTH_BITS'(1);
               reload <= 1'b1;
            end else begin
               tx_sh <= {tx_sh[BYTE_W-2:0], 1'b0};
            end
         end

         if (state_nxt != ST_RD_DATA) miso <= 1'b0;
      end
   end

   spi_mem_array #(
      .DEPTH_BITS (DEPTH_BITS)
   ) u_array (
      .clk       (clk),
      .rd_addr   (ptr),
      .rd_data_c (rd_data_c),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data),
      .spi_we    (spi_we_c),
      .spi_addr  (ptr),
      .spi_data  (rx_byte_c)
   );

endmodule

// File: tb/tb_spi_mem_responder.sv
// Testbench for spi_mem_responder: SPI initiator driver, byte-array reference
// model, and a scoreboard monitor that checks miso on every sclk rising edge.
module tb_spi_mem_responder;

   localparam int HALF = 50;
   localparam logic [7:0] RD = 8'h03;
   localparam logic [7:0] WR = 8'h02;

   logic       clk, rst, sclk, mosi, cs_n, miso, miso_oe, load_en, busy, cmd_err;
   logic [7:0] load_addr, load_data;

   logic [7:0] model [256];
   logic [7:0] exp_q [$];
   int         n_cmp = 0;
   int         n_bad = 0;
   bit         rd_phase = 0;
   bit         mon_en = 1;

   spi_mem_responder dut (
      .clk       (clk),
      .rst       (rst),
      .sclk      (sclk),
      .mosi      (mosi),
      .cs_n      (cs_n),
      .miso      (miso),
      .miso_oe   (miso_oe),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data),
      .busy      (busy),
      .cmd_err   (cmd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk1(input string name, input logic got, input logic exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
      end
   endtask

   // Scoreboard monitor: read-data bits are assembled and compared with the
   // queue; every other bit of a selected frame must see miso low.
   logic [7:0] mon_byte = 8'h00;
   int         mon_bits = 0;
   always @(posedge sclk) begin
      if (mon_en && !cs_n) begin
         if (rd_phase) begin
            mon_byte = {mon_byte[6:0], miso};
            mon_bits++;
            if (mon_bits == 8) begin
               mon_bits = 0;
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL rd_byte: got %02h expected nothing queued", mon_byte);
               end else begin
                  logic [7:0] e;
                  e = exp_q.pop_front();
                  if (mon_byte !== e) begin
                     n_bad++;
                     $display("FAIL rd_byte: got %02h expected %02h at %0t", mon_byte, e, $time);
                  end
               end
            end
         end else begin
            mon_bits = 0;
            n_cmp++;
            if (miso !== 1'b0) begin
               n_bad++;
               $display("FAIL miso_quiet: got %b expected 0 at %0t", miso, $time);
            end
         end
      end
   end

   task automatic backdoor(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      load_en = 1'b1; load_addr = a; load_data = d;
      @(negedge clk);
      load_en = 1'b0;
      model[a] = d;
   endtask

   task automatic cs_begin();
      @(negedge clk);
      cs_n = 1'b0;
      #HALF;
   endtask

   task automatic cs_end();
      #HALF cs_n = 1'b1;
      #(6*HALF);
   endtask

   // Sends the top nbits of b, MSB first, mode 0
   task automatic send_byte(input logic [7:0] b, input int nbits);
      for (int i = 7; i >= 8 - nbits; i--) begin
         mosi = b[i];
         #HALF sclk = 1'b1;
         #HALF sclk = 1'b0;
      end
   endtask

   task automatic send_addr(input logic [23:0] a);
      for (int i = 0; i < 3; i++) send_byte(a[23-8*i -: 8], 8);
   endtask

   task automatic do_read(input logic [23:0] a, input int n);
      logic [7:0] idx;
      cs_begin();
      send_byte(RD, 8);
      chk1("busy_in_frame", busy, 1'b1);
      chk1("oe_in_frame", miso_oe, 1'b1);
      send_addr(a);
      for (int i = 0; i < n; i++) begin
         idx = a[7:0] + 8'(i);
         exp_q.push_back(model[idx]);
      end
      rd_phase = 1'b1;
      for (int i = 0; i < n; i++) send_byte(8'($urandom), 8);
      rd_phase = 1'b0;
      cs_end();
   endtask

   // n complete bytes, then cut_bits bits of a byte that must be discarded
   task automatic do_write(input logic [23:0] a, input int n, input int cut_bits);
      logic [7:0] d, idx;
      cs_begin();
      send_byte(WR, 8);
      send_addr(a);
      for (int i = 0; i < n; i++) begin
         d = 8'($urandom);
         send_byte(d, 8);
         idx = a[7:0] + 8'(i);
         model[idx] = d;
      end
      if (cut_bits > 0) send_byte(8'($urandom), cut_bits);
      cs_end();
   endtask

   task automatic run_random(input int iters);
      logic [7:0]  a;
      logic [23:0] fa;
      for (int t = 0; t < iters; t++) begin
         a  = (t % 3 == 0) ? 8'hFE + 8'($urandom_range(0, 3)) : 8'($urandom);
         fa = {16'($urandom), a};
         case ($urandom_range(0, 3))
            0: do_read(fa, $urandom_range(1, 4));
            1: do_write(fa, $urandom_range(1, 3), 0);
            2: backdoor(a, 8'($urandom));
            default: do_write(fa, $urandom_range(0, 2), $urandom_range(1, 7));
         endcase
      end
   endtask

   initial begin
      logic [7:0] d;
      rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1;
      load_en = 1'b0; load_addr = '0; load_data = '0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk1("rst_miso", miso, 1'b0);
      chk1("rst_miso_oe", miso_oe, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_cmd_err", cmd_err, 1'b0);

      for (int i = 0; i < 256; i++) backdoor(8'(i), 8'($urandom));

      // Basic read
      backdoor(8'h10, 8'hAA); backdoor(8'h11, 8'hBB);
      backdoor(8'h12, 8'hCC); backdoor(8'h13, 8'hDD);
      do_read(24'h000010, 4);
      chk1("busy_after_read", busy, 1'b0);

      // Write then read back
      cs_begin();
      send_byte(WR, 8); send_addr(24'h000020);
      send_byte(8'h12, 8); send_byte(8'h34, 8);
      cs_end();
      model[8'h20] = 8'h12; model[8'h21] = 8'h34;
      do_read(24'h000020, 2);

      // Pointer wrap; upper address bits ignored
      backdoor(8'hFF, 8'h5A); backdoor(8'h00, 8'hC3);
      do_read(24'h0000FF, 2);
      do_read(24'hABCDFF, 3);

      // Unknown command
      chk1("cmd_err_before", cmd_err, 1'b0);
      cs_begin();
      send_byte(8'h9F, 8);
      chk1("cmd_err_set", cmd_err, 1'b1);
      chk1("busy_ignore", busy, 1'b1);
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), 8);
      cs_end();
      chk1("cmd_err_sticky", cmd_err, 1'b1);
      do_read(24'h000010, 4);

      // Write aborted after 5 data bits
      do_write(24'h000040, 0, 5);
      chk1("busy_after_abort", busy, 1'b0);
      chk1("oe_after_abort", miso_oe, 1'b0);
      do_read(24'h00003F, 3);

      // Backdoor load collides with the SPI commit of the same byte
      cs_begin();
      send_byte(WR, 8); send_addr(24'h000050);
      d = 8'h3C;
      send_byte(d, 7);
      load_en = 1'b1; load_addr = 8'h50; load_data = 8'hE7;
      send_byte({d[0], 7'd0}, 1);
      load_en = 1'b0;
      model[8'h50] = 8'hE7;
      cs_end();
      do_read(24'h000050, 1);

      // Reset in the middle of a read
      chk1("cmd_err_pre_rst", cmd_err, 1'b1);
      mon_en = 1'b0;
      cs_begin();
      send_byte(RD, 8); send_addr(24'h000010);
      send_byte(8'h00, 3);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk1("midrst_miso", miso, 1'b0);
      chk1("midrst_busy", busy, 1'b0);
      chk1("midrst_cmd_err", cmd_err, 1'b0);
      chk1("midrst_oe", miso_oe, 1'b0);
      cs_end();
      mon_en = 1'b1;
      do_read(24'h000010, 4);

      run_random(24);

      // Full dump checks every byte against the model and wraps once
      do_read(24'h000080, 257);
      chk8("exp_q_drained", 8'(exp_q.size()), 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
